// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared cpu writeback defaults and the arbiter winner-select encoding.
package wb_arb_pkg;
   localparam int DEPTH_DEF = 2;
   localparam int DW_DEF    = 16;
   localparam int RW_DEF    = 3;

   typedef enum logic [1:0] {SEL_NONE, SEL_LD, SEL_BUF, SEL_PIPE} winSel_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: holds pipeline writeback results that lost arbitration, oldest first.
// Ports: clk, rst_n (async active-low); push/pushReg/pushData write the tail;
// pop retires the head; headReg/headData show the oldest entry; count/full give occupancy;
// entryRegs/entryValid expose every slot's destination register and valid bit.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int DW = 16,
   parameter int RW = 3,
   parameter int CW = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [RW-1:0]       pushReg,
   input  logic [DW-1:0]       pushData,
   input  logic                pop,
   output logic [RW-1:0]       headReg,
   output logic [DW-1:0]       headData,
   output logic [CW-1:0]       count,
   output logic                full,
   output logic [DEPTH*RW-1:0] entryRegs,
   output logic [DEPTH-1:0]    entryValid
);
   localparam int PW = $clog2(DEPTH);

   logic [RW-1:0] regMem [DEPTH];
   logic [DW-1:0] dataMem [DEPTH];
   logic [PW-1:0] wrPtr, rdPtr;
   logic pushOk, popOk;

   // Guards keep occupancy inside [0, DEPTH] even if a caller misbehaves.
   assign full = count == CW'(DEPTH);
   assign pushOk = push && !full;
   assign popOk = pop && count != '0;
   assign headReg = regMem[rdPtr];
   assign headData = dataMem[rdPtr];

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign entryRegs[i*RW +: RW] = regMem[i];
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         entryValid <= '0;
      end else begin
         if (popOk) begin
            rdPtr <= rdPtr + 1'b1;
            entryValid[rdPtr] <= 1'b0;
         end
         if (pushOk) begin
            wrPtr <= wrPtr + 1'b1;
            entryValid[wrPtr] <= 1'b1;
         end
         count <= count + CW'(pushOk) - CW'(popOk);
      end
   end

   always_ff @(posedge clk) begin
      if (pushOk) begin
         regMem[wrPtr] <= pushReg;
         dataMem[wrPtr] <= pushData;
      end
   end
endmodule

// File: rtl/wb_arb.sv
// wb_arb: register-file write-port arbiter between unstallable load returns and
// stallable pipeline results, with a small buffer for pipeline results that lose.
// Ports: clk, rst_n (async active-low); pipe_valid/pipe_reg/pipe_data in, pipe_stall out;
// ld_valid/ld_reg/ld_data in; wr_en/wr_reg/wr_data registered write port;
// busy_mask flags registers with a buffered write still pending.
module wb_arb
   import wb_arb_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_valid,
   input  logic [RW-1:0]     pipe_reg,
   input  logic [DW-1:0]     pipe_data,
   output logic              pipe_stall,
   input  logic              ld_valid,
   input  logic [RW-1:0]     ld_reg,
   input  logic [DW-1:0]     ld_data,
   output logic              wr_en,
   output logic [RW-1:0]     wr_reg,
   output logic [DW-1:0]     wr_data,
   output logic [2**RW-1:0]  busy_mask
);
   localparam int CW = $clog2(DEPTH) + 1;

   winSel_e winSel;
   logic accept, push, pop, full;
   logic [CW-1:0] count;
   logic [RW-1:0] headReg, selReg;
   logic [DW-1:0] headData, selData;
   logic [DEPTH*RW-1:0] entryRegs;
   logic [DEPTH-1:0] entryValid;

   // Stall depends only on registered occupancy, so it never loops back through pipe_valid.
   assign pipe_stall = full;
   assign accept = pipe_valid && !full;

   always_comb begin
      winSel = SEL_NONE;
      if (ld_valid) winSel = SEL_LD;
      else if (count != '0) winSel = SEL_BUF;
      else if (accept) winSel = SEL_PIPE;
      selReg = ld_valid ? ld_reg : (count != '0) ? headReg : pipe_reg;
      selData = ld_valid ? ld_data : (count != '0) ? headData : pipe_data;
   end

   // An accepted result that cannot write now queues behind older ones.
   assign pop = winSel == SEL_BUF;
   assign push = accept && winSel != SEL_PIPE;

   wb_fifo #(.DEPTH(DEPTH), .DW(DW), .RW(RW), .CW(CW)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(push),
      .pushReg(pipe_reg),
      .pushData(pipe_data),
      .pop(pop),
      .headReg(headReg),
      .headData(headData),
      .count(count),
      .full(full),
      .entryRegs(entryRegs),
      .entryValid(entryValid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en <= 1'b0;
         wr_reg <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= winSel != SEL_NONE;
         if (winSel != SEL_NONE) begin
            wr_reg <= selReg;
            wr_data <= selData;
         end
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int k = 0; k < DEPTH; k++)
         if (entryValid[k]) busy_mask[entryRegs[k*RW +: RW]] = 1'b1;
   end
endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the pipeline-result buffer entry count (power of two, >=2).
REQ-002 Parameter DW, default 16, SHALL set the write-data width.
REQ-003 Parameter RW, default 3, SHALL set the register-index width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 pipe_valid  input  1  SHALL flag a pipeline writeback result (already muxed PC/readData/aluOut/specOps).
REQ-007 pipe_reg  input  RW  SHALL carry the pipeline destination register.
REQ-008 pipe_data  input  DW  SHALL carry the pipeline write data.
REQ-009 pipe_stall  output  1  SHALL tell the pipeline its result is not accepted this cycle.
REQ-010 ld_valid  input  1  SHALL flag a multi-cycle memory load return; it cannot be stalled.
REQ-011 ld_reg  input  RW  SHALL carry the load destination register.
REQ-012 ld_data  input  DW  SHALL carry the load data.
REQ-013 wr_en  output  1  SHALL enable the register-file write port.
REQ-014 wr_reg  output  RW  SHALL carry the register-file write index.
REQ-015 wr_data  output  DW  SHALL carry the register-file write data.
REQ-016 busy_mask  output  2**RW  SHALL set bit i iff a buffered entry targets register i.

Function
REQ-017 Pipe accept SHALL be pipe_valid && !pipe_stall; pipe_stall SHALL equal (count == DEPTH), from registered count only.
REQ-018 Each cycle exactly one winner SHALL be chosen in priority: ld_valid; else buffer head (count>0); else accepted pipe input; else none.
REQ-019 wr_en/wr_reg/wr_data SHALL be registered: winner at cycle T appears on the port at T+1 for exactly one cycle.
REQ-020 wr_en SHALL be 0 in any cycle following a cycle with no winner; wr_reg/wr_data SHALL hold last values then.
REQ-021 An accepted pipe result that is not the winner SHALL be pushed to buffer tail the same cycle.
REQ-022 Head pop and tail push in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-023 Buffered results SHALL be written in acceptance order; no entry SHALL be dropped or duplicated.
REQ-024 Load and pipe to the same register in the same cycle: load SHALL write at T+1, pipe at T+2 (pipe value final).
REQ-025 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-026 busy_mask SHALL be combinational from buffer contents and valid bits, updated the cycle after push/pop.
REQ-027 Continuous ld_valid SHALL starve the buffer; pipe_stall SHALL stay high while full, no timeout.

Reset
REQ-028 rst_n low SHALL asynchronously clear count, pointers, entry valid bits, wr_en, wr_reg, wr_data to 0.
REQ-029 During reset pipe_stall SHALL be 0 and busy_mask SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all buffered entries; first write after release requires a new request.

Structure
REQ-031 DEPTH/DW/RW defaults and the winner-select encoding (NONE, LD, BUF, PIPE) SHALL live in the shared cpu package.
REQ-032 The buffer SHALL be a sub-module wb_fifo (push, pop, head, count, full, per-entry reg outputs); arbitration stays in wb_arb.

Verification
REQ-033 Reset then pipe_valid=1, pipe_reg=3, pipe_data=16'h1234, no load -> wr_en=1, wr_reg=3, wr_data=16'h1234 next cycle, pipe_stall=0.
REQ-034 Same cycle ld(r2, 16'hAAAA) and pipe(r2, 16'h5555) -> T+1 writes r2=AAAA, T+2 writes r2=5555, busy_mask bit2 high only at T+1.
REQ-035 ld_valid held 4 cycles with pipe_valid held, data 1,2,3 -> 2 accepted, pipe_stall=1 from cycle 2; after ld drops, writes 1,2,3 in order.
REQ-036 Buffer holding 1 entry, no load, new pipe push -> head written, count stays 1, no stall.
REQ-037 rst_n asserted asynchronously with buffer full -> wr_en, pipe_stall, busy_mask 0 immediately; no buffered write after release.
